// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
//   state_t : FSM state enum (HOLD/WAIT/STAB/RUN), 2 bits
//   ENC_*   : raw state encodings as seen on the status port
//   cnt_w   : counter width for a given cycle count (never below 1 bit)
package pll_reset_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_STAB = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [STATE_W-1:0] ENC_HOLD = 2'd0;
  localparam logic [STATE_W-1:0] ENC_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ENC_STAB = 2'd2;
  localparam logic [STATE_W-1:0] ENC_RUN  = 2'd3;

  // Width of a counter that must reach n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchronizer for level signals crossing into clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output (2 cycles of latency)
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock to system reset sequencer.
// Holds sys_resetn low until the synchronized PLL lock has been stable for
// STABLE_CYCLES, glitch-filters lock loss while running, counts unlocks and
// honours software reset requests.
//   clk           : PLL output clock
//   resetn        : asynchronous active-low reset
//   pll_locked    : raw PLL lock (asynchronous)
//   sw_rst_req    : single-cycle software reset request
//   clr_status    : single-cycle clear of unlock_sticky / unlock_cnt
//   sys_resetn    : registered system reset, active-low
//   ready         : high only in RUN (same as sys_resetn)
//   unlock_sticky : set by any unlock event seen in RUN
//   unlock_cnt    : saturating unlock event count
//   state         : current FSM state encoding
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned GLITCH_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pll_locked,
  input  logic             sw_rst_req,
  input  logic             clr_status,
  output logic             sys_resetn,
  output logic             ready,
  output logic             unlock_sticky,
  output logic [CNT_W-1:0] unlock_cnt,
  output logic [1:0]       state
);

  localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int unsigned STAB_W = cnt_w(STABLE_CYCLES);
  localparam int unsigned GLT_W  = cnt_w(GLITCH_CYCLES);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [GLT_W-1:0]  GLT_LAST  = GLT_W'(GLITCH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [GLT_W-1:0]  glitch_q, glitch_d;
  logic              unlock_evt;
  logic              lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Next-state and counter logic; every counter is left at 0 when its state exits.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stab_d     = stab_q;
    glitch_d   = glitch_q;
    unlock_evt = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (sw_rst_req) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_WAIT;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_WAIT: begin
        stab_d = '0;
        if (sw_rst_req) begin
          state_d = ST_HOLD;
        end else if (lock_s) begin
          state_d = ST_STAB;
        end
      end
      ST_STAB: begin
        if (sw_rst_req) begin
          state_d = ST_HOLD;
          stab_d  = '0;
        end else if (!lock_s) begin
          state_d = ST_WAIT;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_RUN;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end
      ST_RUN: begin
        if (lock_s) begin
          glitch_d = '0;
        end else if (glitch_q == GLT_LAST) begin
          unlock_evt = 1'b1;
        end else begin
          glitch_d = glitch_q + GLT_W'(1);
        end
        // An unlock coinciding with a software request is still an unlock.
        if (unlock_evt || sw_rst_req) begin
          state_d  = ST_HOLD;
          glitch_d = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q        <= '0;
      stab_q        <= '0;
      glitch_q      <= '0;
      sys_resetn    <= 1'b0;
      unlock_sticky <= 1'b0;
      unlock_cnt    <= '0;
    end else begin
      hold_q     <= hold_d;
      stab_q     <= stab_d;
      glitch_q   <= glitch_d;
      sys_resetn <= (state_d == ST_RUN);
      // An unlock event beats a simultaneous clear: the clear acts first.
      if (unlock_evt) begin
        unlock_sticky <= 1'b1;
        if (clr_status) begin
          unlock_cnt <= CNT_W'(1);
        end else if (!(&unlock_cnt)) begin
          unlock_cnt <= unlock_cnt + CNT_W'(1);
        end
      end else if (clr_status) begin
        unlock_sticky <= 1'b0;
        unlock_cnt    <= '0;
      end
    end
  end

  assign ready = sys_resetn;
  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq with a timestamp-based reference model.
module tb_pll_reset_seq;

  localparam int unsigned STABLE_C = 8;
  localparam int unsigned GLITCH_C = 4;
  localparam int unsigned HOLD_C   = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             pll_locked = 1'b0;
  logic             sw_rst_req = 1'b0;
  logic             clr_status = 1'b0;
  logic             sys_resetn;
  logic             ready;
  logic             unlock_sticky;
  logic [CNT_W-1:0] unlock_cnt;
  logic [1:0]       state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .STABLE_CYCLES (STABLE_C),
    .GLITCH_CYCLES (GLITCH_C),
    .HOLD_CYCLES   (HOLD_C),
    .CNT_W         (CNT_W)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .clr_status    (clr_status),
    .sys_resetn    (sys_resetn),
    .ready         (ready),
    .unlock_sticky (unlock_sticky),
    .unlock_cnt    (unlock_cnt),
    .state         (state)
  );

  // Reference model: phases tracked by entry timestamps rather than counters.
  // Phase numbers are the published encodings (0 HOLD, 1 WAIT, 2 STAB, 3 RUN).
  int       m_cyc, m_enter, m_high, m_phase, m_cnt;
  bit       m_sticky, m_rst;
  bit [1:0] m_hist;

  always @(posedge clk or negedge resetn) begin : ref_model
    int np, ne, nh, nc;
    bit ls, evt;
    if (!resetn) begin
      m_cyc <= 0; m_enter <= 0; m_high <= 0; m_phase <= 0;
      m_cnt <= 0; m_sticky <= 0; m_rst <= 0; m_hist <= 2'b00;
    end else begin
      ls = m_hist[1];
      np = m_phase; ne = m_enter; nh = m_high; evt = 0;
      case (m_phase)
        0: if (sw_rst_req) ne = m_cyc + 1;
           else if (m_cyc - m_enter + 1 == int'(HOLD_C)) np = 1;
        1: if (sw_rst_req) np = 0; else if (ls) np = 2;
        2: if (sw_rst_req) np = 0; else if (!ls) np = 1;
           else if (m_cyc - m_enter + 1 == int'(STABLE_C)) np = 3;
        default: begin
          if (ls) nh = m_cyc;
          else if (m_cyc - m_high == int'(GLITCH_C)) evt = 1;
          if (evt || sw_rst_req) np = 0;
        end
      endcase
      if (np != m_phase) begin
        ne = m_cyc + 1;
        nh = m_cyc;
      end
      nc = m_cnt;
      if (evt) nc = clr_status ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
      else if (clr_status) nc = 0;
      m_cnt    <= nc;
      m_sticky <= evt ? 1'b1 : (clr_status ? 1'b0 : m_sticky);
      m_phase  <= np;
      m_enter  <= ne;
      m_high   <= nh;
      m_rst    <= (np == 3);
      m_hist   <= {m_hist[0], pll_locked};
      m_cyc    <= m_cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lock);
    resetn = 1'b0; pll_locked = lock; sw_rst_req = 1'b0; clr_status = 1'b0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  task automatic wait_run(output int n, output bit ok);
    n = 0;
    while (state !== 2'd3 && n < 200) begin
      tick();
      n++;
    end
    ok = (state === 2'd3);
  endtask

  // Drop lock long enough for a genuine unlock; returns on the event edge.
  task automatic unlock_pulse();
    pll_locked = 1'b0;
    repeat (GLITCH_C) tick();
    pll_locked = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    n_checks++; if (sys_resetn !== 1'b0) begin n_fail++; $display("FAIL reset_sys_resetn got %b want 0", sys_resetn); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_checks++; if (unlock_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b want 0", unlock_sticky); end
    n_checks++; if (unlock_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", unlock_cnt); end
    n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
  endtask

  task automatic test_startup();
    int n; bit ok;
    do_reset(1'b1);
    wait_run(n, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL startup_timeout state %0d want 3", state); end
    n_checks++; if (n != int'(HOLD_C + 1 + STABLE_C)) begin n_fail++; $display("FAIL startup_latency got %0d want %0d", n, HOLD_C + 1 + STABLE_C); end
    n_checks++; if (sys_resetn !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL startup_release sys_resetn %b ready %b want 1 1", sys_resetn, ready); end
    n_checks++; if (unlock_cnt !== '0) begin n_fail++; $display("FAIL startup_cnt got %0d want 0", unlock_cnt); end
  endtask

  task automatic test_stab_glitch();
    int n; bit ok;
    do_reset(1'b1);
    repeat (HOLD_C + 1) tick();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL stab_entry state got %0d want 2", state); end
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL stab_hold state got %0d want 2", state); end
    tick();
    // The synchronized low arrives when RUN would otherwise have been entered.
    n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL stab_drop state got %0d want 1", state); end
    wait_run(n, ok);
    n_checks++; if (!ok || n != int'(STABLE_C + 1)) begin n_fail++; $display("FAIL stab_restart ok %0d cycles %0d want %0d", ok, n, STABLE_C + 1); end
  endtask

  task automatic test_glitch();
    int n; bit ok;
    do_reset(1'b1);
    wait_run(n, ok);
    pll_locked = 1'b0;
    repeat (GLITCH_C - 1) tick();
    pll_locked = 1'b1;
    repeat (6) tick();
    n_checks++; if (state !== 2'd3 || sys_resetn !== 1'b1) begin n_fail++; $display("FAIL glitch_short state %0d sys_resetn %b want 3 1", state, sys_resetn); end
    n_checks++; if (unlock_sticky !== 1'b0) begin n_fail++; $display("FAIL glitch_short_sticky got %b want 0", unlock_sticky); end
    pll_locked = 1'b0;
    repeat (GLITCH_C) tick();
    pll_locked = 1'b1;
    tick();
    n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL glitch_early state got %0d want 3", state); end
    tick();
    n_checks++; if (state !== 2'd0 || sys_resetn !== 1'b0) begin n_fail++; $display("FAIL glitch_unlock state %0d sys_resetn %b want 0 0", state, sys_resetn); end
    n_checks++; if (unlock_sticky !== 1'b1 || unlock_cnt !== 8'd1) begin n_fail++; $display("FAIL glitch_status sticky %b cnt %0d want 1 1", unlock_sticky, unlock_cnt); end
    wait_run(n, ok);
    n_checks++; if (!ok || unlock_cnt !== 8'd1) begin n_fail++; $display("FAIL glitch_relock ok %0d cnt %0d want 1 1", ok, unlock_cnt); end
  endtask

  task automatic test_saturation();
    int n; bit ok;
    do_reset(1'b1);
    for (int i = 0; i < 300; i++) begin
      wait_run(n, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_run_timeout iteration %0d state %0d", i, state); end
      unlock_pulse();
      if (i == 0) begin
        n_checks++; if (unlock_cnt !== 8'd1) begin n_fail++; $display("FAIL sat_first got %0d want 1", unlock_cnt); end
      end
    end
    n_checks++; if (unlock_cnt !== 8'(CNT_MAX)) begin n_fail++; $display("FAIL sat_value got %0d want %0d", unlock_cnt, CNT_MAX); end
    n_checks++; if (unlock_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_sticky got %b want 1", unlock_sticky); end
    // Clear on the same edge as an unlock event.
    wait_run(n, ok);
    pll_locked = 1'b0;
    repeat (GLITCH_C) tick();
    pll_locked = 1'b1;
    tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    n_checks++; if (unlock_cnt !== 8'd1 || unlock_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_collide cnt %0d sticky %b want 1 1", unlock_cnt, unlock_sticky); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    n_checks++; if (unlock_cnt !== '0 || unlock_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_status cnt %0d sticky %b want 0 0", unlock_cnt, unlock_sticky); end
  endtask

  task automatic test_sw_rst();
    int n; bit ok;
    do_reset(1'b1);
    wait_run(n, ok);
    unlock_pulse();
    wait_run(n, ok);
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_checks++; if (state !== 2'd0 || sys_resetn !== 1'b0) begin n_fail++; $display("FAIL sw_enter state %0d sys_resetn %b want 0 0", state, sys_resetn); end
    wait_run(n, ok);
    n_checks++; if (!ok || n != int'(HOLD_C + 1 + STABLE_C)) begin n_fail++; $display("FAIL sw_low_time ok %0d cycles %0d want %0d", ok, n + 1, HOLD_C + 2 + STABLE_C); end
    n_checks++; if (unlock_cnt !== 8'd1 || unlock_sticky !== 1'b1) begin n_fail++; $display("FAIL sw_status cnt %0d sticky %b want 1 1", unlock_cnt, unlock_sticky); end
    // Software request on the unlock edge still counts the unlock.
    pll_locked = 1'b0;
    repeat (GLITCH_C) tick();
    pll_locked = 1'b1;
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    n_checks++; if (unlock_cnt !== 8'd2 || state !== 2'd0) begin n_fail++; $display("FAIL sw_collide cnt %0d state %0d want 2 0", unlock_cnt, state); end
  endtask

  task automatic test_async_reset();
    int n; bit ok;
    do_reset(1'b1);
    wait_run(n, ok);
    unlock_pulse();
    n = 0;
    while (state !== 2'd2 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL async_pre_stab state got %0d want 2", state); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (state !== 2'd0 || unlock_sticky !== 1'b0 || unlock_cnt !== '0) begin n_fail++; $display("FAIL async_stab state %0d sticky %b cnt %0d want 0 0 0", state, unlock_sticky, unlock_cnt); end
    do_reset(1'b1);
    wait_run(n, ok);
    unlock_pulse();
    wait_run(n, ok);
    n_checks++; if (!ok || unlock_cnt !== 8'd1) begin n_fail++; $display("FAIL async_pre_run ok %0d cnt %0d want 1 1", ok, unlock_cnt); end
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (sys_resetn !== 1'b0 || ready !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL async_run sys_resetn %b ready %b state %0d want 0 0 0", sys_resetn, ready, state); end
    n_checks++; if (unlock_sticky !== 1'b0 || unlock_cnt !== '0) begin n_fail++; $display("FAIL async_run_status sticky %b cnt %0d want 0 0", unlock_sticky, unlock_cnt); end
  endtask

  task automatic test_random();
    int lock_left;
    lock_left = 0;
    do_reset(1'b1);
    for (int c = 0; c < 4000; c++) begin
      if (lock_left == 0) begin
        if ($urandom_range(0, 9) < 7) begin
          pll_locked = 1'b1;
          lock_left  = int'($urandom_range(5, 60));
        end else begin
          pll_locked = 1'b0;
          lock_left  = int'($urandom_range(1, 7));
        end
      end
      lock_left--;
      sw_rst_req = ($urandom_range(0, 79) == 0);
      clr_status = ($urandom_range(0, 39) == 0);
      tick();
      n_checks++; if (state !== 2'(m_phase)) begin n_fail++; $display("FAIL rnd_state cycle %0d got %0d want %0d", c, state, m_phase); end
      n_checks++; if (sys_resetn !== m_rst) begin n_fail++; $display("FAIL rnd_sys_resetn cycle %0d got %b want %b", c, sys_resetn, m_rst); end
      n_checks++; if (ready !== m_rst) begin n_fail++; $display("FAIL rnd_ready cycle %0d got %b want %b", c, ready, m_rst); end
      n_checks++; if (unlock_sticky !== m_sticky) begin n_fail++; $display("FAIL rnd_sticky cycle %0d got %b want %b", c, unlock_sticky, m_sticky); end
      n_checks++; if (unlock_cnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt cycle %0d got %0d want %0d", c, unlock_cnt, m_cnt); end
    end
    sw_rst_req = 1'b0;
    clr_status = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stab_glitch();
    test_glitch();
    test_saturation();
    test_sw_rst();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sits at the consuming end of the iCE40 PLL wrapper's `locked` output, clocked by the PLL output clock.
- Holds system logic in reset until lock has been continuously stable, then releases a synchronous-deassert reset.
- Glitch-filters loss of lock and re-asserts reset on a genuine unlock.
- Counts unlock events and honours software reset requests, so downstream cores (gameboy, video) see one clean reset source.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before reset release (>=2).
- GLITCH_CYCLES, 4: consecutive unlocked cycles that count as a real loss of lock (>=1).
- HOLD_CYCLES, 16: minimum cycles `sys_resetn` stays low after any assertion (>=1).
- CNT_W, 8: width of the unlock event counter.

Ports:
- clk  in  1  PLL output clock; the only clock.
- resetn  in  1  asynchronous active-low reset.
- pll_locked  in  1  raw PLL lock indication; asynchronous to clk.
- sw_rst_req  in  1  single-cycle software reset request pulse.
- clr_status  in  1  single-cycle pulse; clears `unlock_sticky` and `unlock_cnt`.
- sys_resetn  out  1  registered system reset, active-low.
- ready  out  1  high only in RUN.
- unlock_sticky  out  1  set by any unlock event seen in RUN.
- unlock_cnt  out  CNT_W  saturating count of unlock events.
- state  out  2  current FSM state encoding.

Behaviour:
- Reset values (resetn=0, asynchronous): `sys_resetn`=0, `ready`=0, `unlock_sticky`=0, `unlock_cnt`=0, `state`=HOLD, all counters 0, sync flops 0.
- Input synchronization:
  - `pll_locked` passes through a 2-flop synchronizer; only `lock_s` (2nd flop) is used.
  - Raw-to-`lock_s` latency is 2 cycles.
- FSM states and encodings: HOLD=0, WAIT=1, STAB=2, RUN=3.
- HOLD:
  - `hold_cnt` counts 0..HOLD_CYCLES-1.
  - On reaching HOLD_CYCLES-1, go to WAIT.
  - `sw_rst_req` in HOLD restarts `hold_cnt` at 0.
- WAIT:
  - `stab_cnt`=0.
  - If `lock_s`=1, go to STAB.
- STAB:
  - `stab_cnt` increments each cycle `lock_s`=1.
  - Any cycle with `lock_s`=0 returns to WAIT with `stab_cnt` cleared; no glitch filtering in STAB.
  - When `stab_cnt`=STABLE_CYCLES-1 with `lock_s`=1, go to RUN.
  - Entering RUN from WAIT therefore takes STABLE_CYCLES cycles spent in STAB.
- RUN:
  - `glitch_cnt` increments while `lock_s`=0 and clears when `lock_s`=1.
  - When `glitch_cnt` reaches GLITCH_CYCLES-1 with `lock_s`=0, that is an unlock event: set `unlock_sticky`, increment `unlock_cnt` (saturating at all-ones, no wrap), and go to HOLD.
  - Shorter low pulses have no effect.
- `sw_rst_req` in WAIT, STAB or RUN: go to HOLD next cycle. It does not touch the status outputs.
- Outputs:
  - `sys_resetn` is a registered copy of (next_state==RUN): it rises on the same edge `state` becomes RUN and falls on the same edge `state` leaves RUN.
  - `ready` equals `sys_resetn`.
- Simultaneous events:
  - `clr_status` together with an unlock event: the event wins, giving sticky=1 and cnt=1.
  - `sw_rst_req` together with an unlock event in RUN: counted as an unlock event.
- Counter widths: sized with $clog2 of the respective parameter; no counter wraps.
- Reset mid-operation: asynchronous return to reset values in any state, including mid-STAB.

Decomposition:
- Shared package `pll_reset_pkg`: state enum (HOLD/WAIT/STAB/RUN, 2 bits) and the state encoding constants used by the status decoder.
- One sub-module, `sync_2ff` (generic 2-flop synchronizer, async active-low reset to 0), reused for `pll_locked`.
- FSM, counters and status logic stay in `pll_reset_seq`.

Test Plan:
- Release resetn with pll_locked=1 (STABLE_CYCLES=8, HOLD_CYCLES=4) -> `sys_resetn` rises at cycle 4 (HOLD) + 1 (WAIT) + 8 (STAB), ±2 sync cycles; `state`=3; `unlock_cnt`=0.
- In STAB, drop pll_locked for 1 cycle at `stab_cnt`=5 -> FSM returns to WAIT; RUN is reached only after 8 fresh consecutive lock cycles.
- In RUN with GLITCH_CYCLES=4: 3-cycle low pulse -> no change. 4-cycle low pulse -> `sys_resetn`=0, `unlock_sticky`=1, `unlock_cnt`=1; after relock, back to RUN.
- Force 300 unlock events with CNT_W=8 -> `unlock_cnt` saturates at 255. Then `clr_status` -> cnt=0, sticky=0.
- `sw_rst_req` pulse in RUN -> `sys_resetn` low for exactly HOLD_CYCLES plus WAIT/STAB time; `unlock_cnt` unchanged.
- Assert resetn=0 mid-STAB and mid-RUN -> all outputs are at reset values immediately, without waiting for a clk edge.
